// File: rtl/regfile_write_ctrl.sv
// Register file write-port controller: zero-fills x1..x31 after reset,
// then arbitrates the single write port between WB and a debug channel.
//
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_stall                    pipeline stall in effect
//   i_wb_we/addr/data          WB-stage writeback request
//   i_dbg_valid/addr/data      debug write request (valid/ready)
//   o_dbg_ready                debug request accepted when valid is high
//   o_init_busy                zero-fill in progress
//   o_stall_req                ask pipeline control to stall
//   o_we/o_waddr/o_wdata       regfile write port (combinational)
module regfile_write_ctrl #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 5,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_stall,
   input  logic                  i_wb_we,
   input  logic [ADDR_WIDTH-1:0] i_wb_addr,
   input  logic [DATA_WIDTH-1:0] i_wb_data,
   input  logic                  i_dbg_valid,
   input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
   input  logic [DATA_WIDTH-1:0] i_dbg_data,
   output logic                  o_dbg_ready,
   output logic                  o_init_busy,
   output logic                  o_stall_req,
   output logic                  o_we,
   output logic [ADDR_WIDTH-1:0] o_waddr,
   output logic [DATA_WIDTH-1:0] o_wdata
);

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_FORCE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   localparam logic [7:0]            LIMIT     = 8'(STARVE_LIMIT);

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_init_cnt;
   logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;
   logic [7:0]            r_starve_cnt;
   logic [7:0]            w_starve_cnt_nxt;
   logic [7:0]            w_starve_inc;

   logic                  w_wb_eff;
   logic                  w_arb;
   logic                  w_dbg_ready;
   logic                  w_dbg_xfer;
   logic                  w_dbg_blocked;

   logic                  w_we;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [DATA_WIDTH-1:0] w_wdata;

   // x0 is hardwired, so a WB write to it never needs the port.
   assign w_wb_eff      = i_wb_we & ~i_stall & (i_wb_addr != '0);
   assign w_arb         = (r_state != S_INIT);
   assign w_dbg_ready   = w_arb & ~w_wb_eff;
   assign w_dbg_xfer    = i_dbg_valid & w_dbg_ready;
   assign w_dbg_blocked = i_dbg_valid & ~w_dbg_ready;

   assign w_starve_inc  = (r_starve_cnt == 8'hFF) ?
                          r_starve_cnt : r_starve_cnt + 8'd1;

   // Write port mux: fill, then WB, then debug.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      if (r_state == S_INIT) begin
         w_we    = 1'b1;
         w_waddr = r_init_cnt;
      end else if (w_wb_eff) begin
         w_we    = 1'b1;
         w_waddr = i_wb_addr;
         w_wdata = i_wb_data;
      end else if (i_dbg_valid) begin
         // Debug write to x0 completes the handshake but is dropped.
         w_we    = (i_dbg_addr != '0);
         w_waddr = i_dbg_addr;
         w_wdata = i_dbg_data;
      end
   end

   // Reset gating keeps the port quiet even before the async
   // reset has propagated through the state register.
   assign o_we        = w_we & i_rst_n;
   assign o_waddr     = w_waddr;
   assign o_wdata     = w_wdata;
   assign o_dbg_ready = w_dbg_ready & i_rst_n;
   assign o_init_busy = (r_state == S_INIT) | ~i_rst_n;
   assign o_stall_req = (r_state != S_RUN) | ~i_rst_n;

   always_comb begin
      w_state_nxt      = r_state;
      w_init_cnt_nxt   = r_init_cnt;
      w_starve_cnt_nxt = r_starve_cnt;
      unique case (r_state)
         S_INIT: begin
            w_init_cnt_nxt = r_init_cnt + 1'b1;
            if (r_init_cnt == LAST_ADDR) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (w_dbg_xfer) begin
               w_starve_cnt_nxt = 8'd0;
            end else if (w_dbg_blocked) begin
               w_starve_cnt_nxt = w_starve_inc;
               if (w_starve_inc >= LIMIT) begin
                  w_state_nxt = S_FORCE;
               end
            end
         end
         S_FORCE: begin
            // Leave on grant, or if the requester gave up.
            if (w_dbg_xfer || !i_dbg_valid) begin
               w_starve_cnt_nxt = 8'd0;
               w_state_nxt      = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_INIT;
         r_init_cnt   <= ADDR_WIDTH'(1);
         r_starve_cnt <= 8'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_init_cnt   <= w_init_cnt_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Testbench for regfile_write_ctrl: expected port values are queued
// as stimulus is driven and compared when the DUT outputs settle.
module tb_regfile_write_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        dbg_valid;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_ready;
   logic        init_busy;
   logic        stall_req;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;

   typedef struct {
      string       tag;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        rdy;
      logic        busy;
      logic        sreq;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk;
   int   n_pass;

   regfile_write_ctrl #(
      .DATA_WIDTH  (32),
      .ADDR_WIDTH  (5),
      .STARVE_LIMIT(8)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_stall    (stall),
      .i_wb_we    (wb_we),
      .i_wb_addr  (wb_addr),
      .i_wb_data  (wb_data),
      .i_dbg_valid(dbg_valid),
      .i_dbg_addr (dbg_addr),
      .i_dbg_data (dbg_data),
      .o_dbg_ready(dbg_ready),
      .o_init_busy(init_busy),
      .o_stall_req(stall_req),
      .o_we       (we),
      .o_waddr    (waddr),
      .o_wdata    (wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Queue the expectation, compare at the falling edge, then
   // advance to just after the next rising edge.
   task automatic step(input string tag, input logic e_we,
                       input logic [4:0] e_addr, input logic [31:0] e_data,
                       input logic e_rdy, input logic e_busy,
                       input logic e_sreq);
      exp_t e;
      exp_t o;
      e.tag = tag; e.we = e_we; e.waddr = e_addr; e.wdata = e_data;
      e.rdy = e_rdy; e.busy = e_busy; e.sreq = e_sreq;
      exp_q.push_back(e);
      @(negedge clk);
      o = exp_q.pop_front();
      chk({o.tag, ".we"}, 32'(we), 32'(o.we));
      chk({o.tag, ".rdy"}, 32'(dbg_ready), 32'(o.rdy));
      chk({o.tag, ".busy"}, 32'(init_busy), 32'(o.busy));
      chk({o.tag, ".sreq"}, 32'(stall_req), 32'(o.sreq));
      if (o.we) begin
         chk({o.tag, ".waddr"}, 32'(waddr), 32'(o.waddr));
         chk({o.tag, ".wdata"}, wdata, o.wdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
      dbg_valid = 0; dbg_addr = 0; dbg_data = 0;
   endtask

   task automatic fill(input string tag, input int first, input int last,
                       input logic dv);
      for (int a = first; a <= last; a++) begin
         step(tag, 1'b1, 5'(a), 32'h0, 1'b0, 1'b1, 1'b1);
      end
      if (dv) chk({tag, ".starve"}, 32'(dut.r_starve_cnt), 32'h0);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      step("rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      rst_n = 1;
      #1;

      fill("init", 1, 31, 1'b0);
      step("run0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

      wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
      step("wb5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      stall = 1;
      step("wbstall", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      stall = 0; wb_addr = 0;
      step("wbx0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle_inputs();

      dbg_valid = 1; dbg_addr = 10; dbg_data = 32'h1234;
      step("dbg10", 1'b1, 5'd10, 32'h1234, 1'b1, 1'b0, 1'b0);
      dbg_addr = 0; dbg_data = 32'h5555;
      step("dbgx0", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      idle_inputs();

      // WB hogs the port while debug waits on x7.
      wb_we = 1; wb_addr = 3;
      dbg_valid = 1; dbg_addr = 7; dbg_data = 32'h77;
      for (int i = 1; i <= 8; i++) begin
         wb_data = 32'h100 + 32'(i);
         step($sformatf("blk%0d", i), 1'b1, 5'd3, 32'h100 + 32'(i),
              1'b0, 1'b0, 1'b0);
      end
      wb_data = 32'h200;
      step("force", 1'b1, 5'd3, 32'h200, 1'b0, 1'b0, 1'b1);
      stall = 1;
      step("grant7", 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b1);
      idle_inputs();
      step("unforce", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("starve0", 32'(dut.r_starve_cnt), 32'h0);

      // Reset in the middle of the fill, debug pending throughout.
      rst_n = 0;
      #1;
      rst_n = 1;
      #1;
      dbg_valid = 1; dbg_addr = 9; dbg_data = 32'hABCD;
      fill("fillA", 1, 16, 1'b0);
      rst_n = 0;
      step("midrst1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      step("midrst2", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b1);
      rst_n = 1;
      #1;
      fill("fillB", 1, 31, 1'b1);
      step("dbginit", 1'b1, 5'd9, 32'hABCD, 1'b1, 1'b0, 1'b0);
      idle_inputs();
      step("idle", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
